// File: rtl/xbus_arbiter.sv
// xbus_arbiter: two-master round-robin arbiter in front of the single-cycle
// xbus slave side. A master can lock the bus across a read-modify-write
// sequence; a counter force-releases any lock held for MAX_LOCK cycles.
module xbus_arbiter #(
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_as,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_lock,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_as,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        xbus_as,
    output logic        xbus_we,
    output logic [3:0]  xbus_be,
    output logic [31:0] xbus_addr,
    output logic [31:0] xbus_wdata,
    input  logic [31:0] xbus_rdata,
    output logic        lock_timeout
);

    // Last count value a lock may reach before it is forced off.
    localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

    logic       last_grant_q, last_grant_d;
    logic       lock_valid_q, lock_valid_d;
    logic       lock_owner_q, lock_owner_d;
    logic [7:0] lock_cnt_q,   lock_cnt_d;
    logic       lock_timeout_q, lock_timeout_d;

    logic gnt0, gnt1;
    logic owner_lock;

    // Grant decision: lock owner first, then lone requester, then round-robin tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (lock_valid_q) begin
            // The non-owner waits even when the owner leaves the bus idle.
            if (lock_owner_q) gnt1 = m1_as;
            else              gnt0 = m0_as;
        end else if (m0_as && !m1_as) begin
            gnt0 = 1'b1;
        end else if (m1_as && !m0_as) begin
            gnt1 = 1'b1;
        end else if (m0_as && m1_as) begin
            if (last_grant_q) gnt0 = 1'b1;
            else              gnt1 = 1'b1;
        end
    end

    // Slave-side mux and per-master responses; everything is zero without a grant.
    always_comb begin
        xbus_as    = gnt0 | gnt1;
        xbus_we    = 1'b0;
        xbus_be    = 4'h0;
        xbus_addr  = 32'h0;
        xbus_wdata = 32'h0;
        if (gnt0) begin
            xbus_we    = m0_we;
            xbus_be    = m0_be;
            xbus_addr  = m0_addr;
            xbus_wdata = m0_wdata;
        end else if (gnt1) begin
            xbus_we    = m1_we;
            xbus_be    = m1_be;
            xbus_addr  = m1_addr;
            xbus_wdata = m1_wdata;
        end
        m0_ready     = gnt0;
        m1_ready     = gnt1;
        m0_rdata     = gnt0 ? xbus_rdata : 32'h0;
        m1_rdata     = gnt1 ? xbus_rdata : 32'h0;
        lock_timeout = lock_timeout_q & ~rst;
    end

    assign owner_lock = lock_owner_q ? m1_lock : m0_lock;

    // Next-state for round-robin pointer, lock ownership and lock timeout.
    always_comb begin
        last_grant_d   = last_grant_q;
        lock_valid_d   = lock_valid_q;
        lock_owner_d   = lock_owner_q;
        lock_cnt_d     = lock_cnt_q;
        lock_timeout_d = 1'b0;

        if (gnt0 || gnt1) last_grant_d = gnt1;

        if (lock_valid_q) begin
            // With lock held only the owner can complete, so a dropped lock
            // bit releases whether or not the owner is on the bus.
            if (!owner_lock) begin
                lock_valid_d = 1'b0;
            end else if (lock_cnt_q == LOCK_LAST) begin
                // Forced release; the owner's lock request this cycle is dropped
                // and pointing last_grant at it hands the next tie to the other master.
                lock_valid_d   = 1'b0;
                last_grant_d   = lock_owner_q;
                lock_timeout_d = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_q + 8'd1;
            end
        end else if (gnt0 && m0_lock) begin
            lock_valid_d = 1'b1;
            lock_owner_d = 1'b0;
            lock_cnt_d   = 8'd0;
        end else if (gnt1 && m1_lock) begin
            lock_valid_d = 1'b1;
            lock_owner_d = 1'b1;
            lock_cnt_d   = 8'd0;
        end
    end

    // State registers; reset points last_grant at m1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q   <= 1'b1;
            lock_valid_q   <= 1'b0;
            lock_owner_q   <= 1'b0;
            lock_cnt_q     <= 8'd0;
            lock_timeout_q <= 1'b0;
        end else begin
            last_grant_q   <= last_grant_d;
            lock_valid_q   <= lock_valid_d;
            lock_owner_q   <= lock_owner_d;
            lock_cnt_q     <= lock_cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter (MAX_LOCK=4). Inputs change 1ns after a
// rising edge; outputs are sampled 2ns after the edge.
module tb_xbus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_as, m0_we, m0_lock, m1_as, m1_we, m1_lock;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        xbus_as, xbus_we;
    logic [3:0]  xbus_be;
    logic [31:0] xbus_addr, xbus_wdata, xbus_rdata;
    logic        lock_timeout;

    int total = 0;
    int bad   = 0;

    xbus_arbiter #(.MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .m0_as(m0_as), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_as(m1_as), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .xbus_as(xbus_as), .xbus_we(xbus_we), .xbus_be(xbus_be), .xbus_addr(xbus_addr),
        .xbus_wdata(xbus_wdata), .xbus_rdata(xbus_rdata), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    // advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_as = 1'b1; m0_we = 1'b1; m0_be = 4'hf; m0_addr = 32'h11; m0_wdata = 32'h22; m0_lock = 1'b1;
        m1_as = 1'b1; m1_we = 1'b1; m1_be = 4'hf; m1_addr = 32'h33; m1_wdata = 32'h44; m1_lock = 1'b0;
        xbus_rdata = 32'hffff_ffff;
        tick(); tick();
        #1;
        total++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b%b want 00", m0_ready, m1_ready); end
        total++; if ({xbus_as, xbus_we, xbus_be} !== 6'h0 || xbus_addr !== 32'h0 || xbus_wdata !== 32'h0) begin bad++; $display("FAIL reset_xbus as=%b we=%b be=%h addr=%h wd=%h want 0", xbus_as, xbus_we, xbus_be, xbus_addr, xbus_wdata); end
        total++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0 || lock_timeout !== 1'b0) begin bad++; $display("FAIL reset_rdata r0=%h r1=%h to=%b want 0", m0_rdata, m1_rdata, lock_timeout); end
        m0_as = 1'b0; m0_we = 1'b0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_lock = 1'b0;
        m1_as = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_idle();
        xbus_rdata = 32'hdead_beef;
        m0_addr = 32'h55; m1_addr = 32'h66; m0_we = 1'b1; m1_be = 4'ha;
        #1;
        total++; if (xbus_as !== 1'b0 || xbus_we !== 1'b0 || xbus_be !== 4'h0 || xbus_addr !== 32'h0 || xbus_wdata !== 32'h0) begin bad++; $display("FAIL idle_xbus as=%b addr=%h want 0", xbus_as, xbus_addr); end
        total++; if ({m0_ready, m1_ready} !== 2'b00 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL idle_resp rdy=%b%b r0=%h r1=%h want 0", m0_ready, m1_ready, m0_rdata, m1_rdata); end
        tick();
        m0_we = 1'b0; m1_be = 4'h0;
    endtask

    // Both masters hold as from the first cycle after reset: m0, m1, m0, ...
    task automatic test_contention();
        logic [5:0] exp_g0;
        exp_g0 = 6'b010101; // bit i = m0 granted in cycle i
        m0_as = 1'b1; m0_addr = 32'h100; m1_as = 1'b1; m1_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (m0_ready !== exp_g0[i] || m1_ready !== !exp_g0[i]) begin bad++; $display("FAIL contend_c%0d rdy=%b%b want %b%b", i, m0_ready, m1_ready, exp_g0[i], !exp_g0[i]); end
            total++; if (xbus_addr !== (exp_g0[i] ? 32'h100 : 32'h200) || xbus_as !== 1'b1) begin bad++; $display("FAIL contend_addr_c%0d got %h as=%b", i, xbus_addr, xbus_as); end
            tick();
        end
        m0_as = 1'b0; m1_as = 1'b0;
    endtask

    // m1 lone write, then m0 lone read (leaves last_grant = m0)
    task automatic test_single();
        m1_as = 1'b1; m1_we = 1'b1; m1_be = 4'h3; m1_addr = 32'h3000; m1_wdata = 32'hcafe_f00d;
        xbus_rdata = 32'h0bad_0bad;
        #1;
        total++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin bad++; $display("FAIL single_m1_rdy got %b%b want 01", m0_ready, m1_ready); end
        total++; if (xbus_we !== 1'b1 || xbus_be !== 4'h3 || xbus_addr !== 32'h3000 || xbus_wdata !== 32'hcafe_f00d) begin bad++; $display("FAIL single_m1_xbus we=%b be=%h addr=%h wd=%h", xbus_we, xbus_be, xbus_addr, xbus_wdata); end
        tick();
        m1_as = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        m0_as = 1'b1; m0_we = 1'b0; m0_be = 4'hf; m0_addr = 32'h1000;
        xbus_rdata = 32'h1234_5678;
        #1;
        total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678) begin bad++; $display("FAIL single_m0_read rdy=%b rdata=%h want 1 12345678", m0_ready, m0_rdata); end
        total++; if (xbus_addr !== 32'h1000 || xbus_we !== 1'b0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL single_m0_xbus addr=%h we=%b r1=%h", xbus_addr, xbus_we, m1_rdata); end
        tick();
        m0_as = 1'b0; m0_be = 4'h0; m0_addr = 32'h0;
    endtask

    // m1 locks for 3 transfers while m0 requests throughout
    task automatic test_lock();
        m0_as = 1'b1; m0_addr = 32'h500;
        m1_as = 1'b1; m1_we = 1'b1; m1_addr = 32'h2000; m1_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) m1_lock = 1'b0;
            #1;
            total++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin bad++; $display("FAIL lock_hold_c%0d rdy=%b%b want 01", i, m0_ready, m1_ready); end
            tick();
        end
        m1_as = 1'b0; m1_we = 1'b0;
        #1;
        total++; if (m0_ready !== 1'b1 || xbus_addr !== 32'h500) begin bad++; $display("FAIL lock_after_release rdy=%b addr=%h want 1 500", m0_ready, xbus_addr); end
        tick();
        m0_as = 1'b0;
    endtask

    // m0 holds lock forever with MAX_LOCK=4; m1 waits then wins after timeout
    task automatic test_timeout();
        m0_as = 1'b1; m0_lock = 1'b1;
        #1;
        total++; if (m0_ready !== 1'b1 || lock_timeout !== 1'b0) begin bad++; $display("FAIL to_acquire rdy=%b to=%b want 1 0", m0_ready, lock_timeout); end
        tick();
        m1_as = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || lock_timeout !== 1'b0) begin bad++; $display("FAIL to_locked_c%0d rdy=%b%b to=%b want 10 0", i, m0_ready, m1_ready, lock_timeout); end
            tick();
        end
        #1;
        total++; if (lock_timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got %b want 1", lock_timeout); end
        total++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin bad++; $display("FAIL to_handover rdy=%b%b want 01", m0_ready, m1_ready); end
        tick();
        #1;
        // m0's lock at the timeout cycle was dropped, so this is a plain tie
        total++; if (lock_timeout !== 1'b0 || m0_ready !== 1'b1 || m1_ready !== 1'b0) begin bad++; $display("FAIL to_after to=%b rdy=%b%b want 0 10", lock_timeout, m0_ready, m1_ready); end
        tick();
        m0_as = 1'b0; m0_lock = 1'b0; m1_as = 1'b0;
        tick(); tick();
    endtask

    // m1 owns a lock, goes idle while keeping it; reset drops it
    task automatic test_reset_midlock();
        m1_as = 1'b1; m1_lock = 1'b1; m1_addr = 32'h700;
        #1;
        total++; if (m1_ready !== 1'b1) begin bad++; $display("FAIL rml_acquire got %b want 1", m1_ready); end
        tick();
        m1_as = 1'b0; m0_as = 1'b1; m0_addr = 32'h800;
        #1;
        total++; if (m0_ready !== 1'b0 || xbus_as !== 1'b0) begin bad++; $display("FAIL rml_idle_wait rdy=%b as=%b want 0 0", m0_ready, xbus_as); end
        tick();
        rst = 1'b1; m1_as = 1'b1;
        #1;
        total++; if ({m0_ready, m1_ready, xbus_as} !== 3'b000 || xbus_addr !== 32'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL rml_in_reset rdy=%b%b as=%b addr=%h", m0_ready, m1_ready, xbus_as, xbus_addr); end
        tick();
        rst = 1'b0; m1_lock = 1'b0;
        #1;
        total++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || xbus_addr !== 32'h800) begin bad++; $display("FAIL rml_first_tie rdy=%b%b addr=%h want 10 800", m0_ready, m1_ready, xbus_addr); end
        tick();
        #1;
        total++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin bad++; $display("FAIL rml_second rdy=%b%b want 01", m0_ready, m1_ready); end
        tick();
        m0_as = 1'b0; m1_as = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0_as = 1'b0; m0_we = 1'b0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_lock = 1'b0;
        m1_as = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_lock = 1'b0;
        xbus_rdata = 32'h0;
        test_reset();
        test_idle();
        test_contention();
        test_single();
        test_lock();
        test_timeout();
        test_reset_midlock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
